// File: rtl/rv_pkg.sv
// rv_pkg: RV32I encodings, ALU operation codes and write-back selects shared by the decode stage
package rv_pkg;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_W    = 3'b010;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic WB_SEL_ALU = 1'b0;
   localparam logic WB_SEL_MEM = 1'b1;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   // alt selects SUB/SRA over ADD/SRL; ignored for every other funct3
   function automatic alu_op_e alu_op(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 32-entry register file, two read ports with write-through bypass, x0 hardwired to zero
module reg_file #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [4:0]   ra1_i,
   input  logic [4:0]   ra2_i,
   output logic [W-1:0] rd1_o,
   output logic [W-1:0] rd2_o,
   input  logic         wen_i,
   input  logic [4:0]   wa_i,
   input  logic [W-1:0] wd_i
);
   logic [W-1:0] regs_q [32];
   logic         wr;

   assign wr = wen_i && wa_i != 5'd0;

   // clear everything on reset, otherwise commit non-x0 writes
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (wr) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign rd1_o = ra1_i == 5'd0 ? '0 : (wr && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
   assign rd2_o = ra2_i == 5'd0 ? '0 : (wr && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];
endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID latch, register file, RV32I decoder and load-use stall for the 5-stage pipeline
module id_stage
   import rv_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   input  logic [31:0]     if_pc,
   input  logic            flush,
   input  logic            wb_wen,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic [4:0]      ex_rd,
   input  logic            ex_wb_sel,
   output logic            stall_out,
   output logic [XLEN-1:0] data_1,
   output logic [XLEN-1:0] data_2,
   output logic [4:0]      Rd,
   output logic [3:0]      ALU_ctrl,
   output logic            ALU_src,
   output logic [XLEN-1:0] imm,
   output logic            MEM_wen,
   output logic            WB_sel,
   output logic [31:0]     PC,
   output logic            illegal
);
   logic        valid_q;
   logic [31:0] instr_q, pc_q;
   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [4:0]  rs1, rs2, rd;
   logic [XLEN-1:0] rf1, rf2, imm_d;
   logic        legal, src_d, men_d, wbs_d, has_rd, use1, use2, is_lui, bubble;
   alu_op_e     alu_d;

   assign opc = instr_q[6:0];
   assign rd  = instr_q[11:7];
   assign f3  = instr_q[14:12];
   assign rs1 = instr_q[19:15];
   assign rs2 = instr_q[24:20];
   assign f7  = instr_q[31:25];

   // IF/ID latch: reset > flush > stall > load
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= RESET_PC;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (!stall_out) begin
         valid_q <= if_valid;
         instr_q <= if_instr;
         pc_q    <= if_pc;
      end
   end

   reg_file #(.W(XLEN)) u_rf (
      .clk   (clk),
      .reset (reset),
      .ra1_i (rs1),
      .ra2_i (rs2),
      .rd1_o (rf1),
      .rd2_o (rf2),
      .wen_i (wb_wen),
      .wa_i  (wb_rd),
      .wd_i  (wb_data)
   );

   // decode the latched instruction into legality, controls, immediate and source usage
   always_comb begin
      legal  = 1'b0;
      alu_d  = ALU_ADD;
      src_d  = 1'b0;
      men_d  = 1'b0;
      wbs_d  = WB_SEL_ALU;
      has_rd = 1'b0;
      use1   = 1'b0;
      use2   = 1'b0;
      is_lui = 1'b0;
      imm_d  = '0;
      case (opc)
         OPC_OP: begin
            legal  = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
            alu_d  = alu_op(f3, f7 == F7_ALT);
            has_rd = 1'b1;
            use1   = 1'b1;
            use2   = 1'b1;
         end
         OPC_OPIMM: begin
            legal  = f3 == F3_SLL ? f7 == F7_BASE : f3 == F3_SR ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
            alu_d  = alu_op(f3, f3 == F3_SR && f7 == F7_ALT);
            imm_d  = {{20{instr_q[31]}}, instr_q[31:20]};
            src_d  = 1'b1;
            has_rd = 1'b1;
            use1   = 1'b1;
         end
         OPC_LOAD: begin
            legal  = f3 == F3_W;
            imm_d  = {{20{instr_q[31]}}, instr_q[31:20]};
            src_d  = 1'b1;
            wbs_d  = WB_SEL_MEM;
            has_rd = 1'b1;
            use1   = 1'b1;
         end
         OPC_STORE: begin
            legal = f3 == F3_W;
            imm_d = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            src_d = 1'b1;
            men_d = 1'b1;
            use1  = 1'b1;
            use2  = 1'b1;
         end
         OPC_LUI: begin
            legal  = 1'b1;
            imm_d  = {instr_q[31:12], 12'h000};
            src_d  = 1'b1;
            has_rd = 1'b1;
            is_lui = 1'b1;
         end
         default: ;
      endcase
   end

   assign stall_out = valid_q && legal && ex_wb_sel && ex_rd != 5'd0 &&
                      ((use1 && ex_rd == rs1) || (use2 && ex_rd == rs2));
   assign illegal   = valid_q && !legal;
   assign bubble    = !valid_q || !legal || stall_out;

   assign data_1   = bubble || is_lui ? '0 : rf1;
   assign data_2   = bubble ? '0 : rf2;
   assign Rd       = bubble || !has_rd ? 5'd0 : rd;
   assign ALU_ctrl = bubble ? 4'd0 : alu_d;
   assign ALU_src  = !bubble && src_d;
   assign imm      = bubble ? '0 : imm_d;
   assign MEM_wen  = !bubble && men_d;
   assign WB_sel   = !bubble && wbs_d;
   assign PC       = pc_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors for the decode stage with hand-computed expectations
module tb_id_stage;
   logic        clk = 1'b0;
   logic        reset, if_valid, flush, wb_wen, ex_wb_sel;
   logic [31:0] if_instr, if_pc, wb_data;
   logic [4:0]  wb_rd, ex_rd;
   logic        stall_out, ALU_src, MEM_wen, WB_sel, illegal;
   logic [31:0] data_1, data_2, imm, PC;
   logic [4:0]  Rd;
   logic [3:0]  ALU_ctrl;
   int          n_checks = 0;
   int          n_errors = 0;

   id_stage dut (
      .clk       (clk),
      .reset     (reset),
      .if_valid  (if_valid),
      .if_instr  (if_instr),
      .if_pc     (if_pc),
      .flush     (flush),
      .wb_wen    (wb_wen),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .ex_rd     (ex_rd),
      .ex_wb_sel (ex_wb_sel),
      .stall_out (stall_out),
      .data_1    (data_1),
      .data_2    (data_2),
      .Rd        (Rd),
      .ALU_ctrl  (ALU_ctrl),
      .ALU_src   (ALU_src),
      .imm       (imm),
      .MEM_wen   (MEM_wen),
      .WB_sel    (WB_sel),
      .PC        (PC),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
      wb_wen = 1'b0; wb_rd = '0; wb_data = '0; ex_rd = '0; ex_wb_sel = 1'b0;
      step();
      step();
      check("rst_stall", 32'(stall_out), 0);
      check("rst_illegal", 32'(illegal), 0);
      check("rst_d1", data_1, 0);
      check("rst_d2", data_2, 0);
      check("rst_rd", 32'(Rd), 0);
      check("rst_alu", 32'(ALU_ctrl), 0);
      check("rst_src", 32'(ALU_src), 0);
      check("rst_imm", imm, 0);
      check("rst_men", 32'(MEM_wen), 0);
      check("rst_wbs", 32'(WB_sel), 0);
      check("rst_pc", PC, 32'h0);
      reset = 1'b0;
      if_valid = 1'b1;
      for (int i = 1; i < 32; i++) begin
         if_instr = {7'b0, 5'(i), 5'(i), 3'b000, 5'd1, 7'b0110011};
         step();
         check("rf_zero", data_1 | data_2, 0);
      end
      // ADDI x1,x0,5
      if_instr = 32'h00500093; if_pc = 32'h100;
      step();
      check("addi_rd", 32'(Rd), 1);
      check("addi_imm", imm, 5);
      check("addi_src", 32'(ALU_src), 1);
      check("addi_alu", 32'(ALU_ctrl), 0);
      check("addi_d1", data_1, 0);
      check("addi_wbs", 32'(WB_sel), 0);
      check("addi_men", 32'(MEM_wen), 0);
      check("addi_pc", PC, 32'h100);
      // ADD x2,x1,x1 with same-cycle write-back of x1
      if_instr = 32'h00108133; if_pc = 32'h104;
      step();
      wb_wen = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
      #1;
      check("byp_d1", data_1, 32'h1234);
      check("byp_d2", data_2, 32'h1234);
      step();
      wb_wen = 1'b0;
      #1;
      check("rf_x1", data_1, 32'h1234);
      // write to x0 ignored
      if_instr = 32'h00000133;
      step();
      wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
      #1;
      check("x0_byp", data_1, 0);
      step();
      wb_wen = 1'b0;
      #1;
      check("x0_rd", data_1 | data_2, 0);
      // load-use on rs1: ADD x4,x3,x0
      if_instr = 32'h00018233; if_pc = 32'h200;
      step();
      ex_rd = 5'd3; ex_wb_sel = 1'b1;
      #1;
      check("lu_stall", 32'(stall_out), 1);
      check("lu_rd", 32'(Rd), 0);
      check("lu_pc", PC, 32'h200);
      if_instr = 32'h00500093; if_pc = 32'h204;
      step();
      ex_rd = 5'd0;
      #1;
      check("lu_release", 32'(stall_out), 0);
      check("lu_hold_rd", 32'(Rd), 4);
      check("lu_hold_pc", PC, 32'h200);
      check("lu_hold_alu", 32'(ALU_ctrl), 0);
      ex_wb_sel = 1'b0;
      // SUB x3,x1,x2
      if_instr = 32'h402081B3;
      step();
      check("sub_alu", 32'(ALU_ctrl), 1);
      check("sub_src", 32'(ALU_src), 0);
      check("sub_rd", 32'(Rd), 3);
      // SRAI x1,x1,3
      if_instr = 32'h4030D093;
      step();
      check("srai_alu", 32'(ALU_ctrl), 7);
      check("srai_src", 32'(ALU_src), 1);
      // LUI x7,0x12345 (rs1 field = 8, not a real source)
      if_instr = 32'h123453B7;
      step();
      ex_rd = 5'd8; ex_wb_sel = 1'b1;
      wb_wen = 1'b1; wb_rd = 5'd8; wb_data = 32'hAAAA;
      #1;
      check("lui_stall", 32'(stall_out), 0);
      check("lui_d1", data_1, 0);
      check("lui_imm", imm, 32'h12345000);
      check("lui_rd", 32'(Rd), 7);
      // SW x5,-4(x6)
      if_instr = 32'hFE532E23;
      step();
      wb_wen = 1'b0; ex_rd = 5'd5; ex_wb_sel = 1'b0;
      #1;
      check("sw_imm", imm, 32'hFFFFFFFC);
      check("sw_men", 32'(MEM_wen), 1);
      check("sw_rd", 32'(Rd), 0);
      check("sw_src", 32'(ALU_src), 1);
      check("sw_nostall", 32'(stall_out), 0);
      ex_wb_sel = 1'b1;
      #1;
      check("sw_rs2_stall", 32'(stall_out), 1);
      ex_wb_sel = 1'b0; ex_rd = 5'd0;
      // LW x9,8(x8): x8 holds 0xAAAA
      if_instr = 32'h00842483;
      step();
      check("lw_wbs", 32'(WB_sel), 1);
      check("lw_d1", data_1, 32'hAAAA);
      check("lw_imm", imm, 8);
      check("lw_rd", 32'(Rd), 9);
      // unsupported encodings
      if_instr = 32'h0000007F;
      step();
      check("ill_op", 32'(illegal), 1);
      check("ill_rd", 32'(Rd), 0);
      check("ill_src", 32'(ALU_src), 0);
      if_instr = 32'h02208133;
      step();
      check("ill_f7", 32'(illegal), 1);
      // flush together with stall
      if_instr = 32'h00018233; if_pc = 32'h300;
      step();
      ex_rd = 5'd3; ex_wb_sel = 1'b1; flush = 1'b1;
      #1;
      check("fl_stall", 32'(stall_out), 1);
      step();
      flush = 1'b0;
      #1;
      check("fl_nostall", 32'(stall_out), 0);
      check("fl_rd", 32'(Rd), 0);
      check("fl_illegal", 32'(illegal), 0);
      // reset while stalled
      step();
      check("rs_stall", 32'(stall_out), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("rs_clear", 32'(stall_out), 0);
      check("rs_pc", PC, 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
